// File: rtl/down_counter_ctrl.sv
// Loadable down counter with a registered one-cycle terminal-count pulse,
// supporting one-shot (stop at zero) and auto-reload operation.
module down_counter_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;
  logic             tc_r, tc_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      tc_r   <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      reload <= reload_nxt;
      tc_r   <= tc_nxt;
    end
  end

  // Load overrides everything, including an expiry in the same cycle.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload;
    tc_nxt     = 1'b0;
    if (load) begin
      state_nxt  = RUN;
      count_nxt  = load_val;
      reload_nxt = load_val;
    end else begin
      unique case (state)
        RUN: begin
          if (en) begin
            if (count != '0) begin
              count_nxt = count - 1'b1;
            end else begin
              tc_nxt = 1'b1;
              if (mode) begin
                count_nxt = reload;
              end else begin
                state_nxt = DONE;
              end
            end
          end
        end
        DONE: count_nxt = '0;
        default: ;
      endcase
    end
  end

  assign q    = count;
  assign tc   = tc_r;
  assign busy = (state == RUN);

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Directed vector bench for down_counter_ctrl (WIDTH=4).
module tb_down_counter_ctrl;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             mode;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;

  int errors = 0;
  int checks = 0;

  down_counter_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .mode     (mode),
    .q        (q),
    .tc       (tc),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             load;
    logic [WIDTH-1:0] val;
    logic             en;
    logic             mode;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic l, int v, logic e, logic m, int eq, logic etc, logic eb);
    vec_t r;
    r.load = l; r.val = WIDTH'(v); r.en = e; r.mode = m;
    r.q = WIDTH'(eq); r.tc = etc; r.busy = eb;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int eq, input int etc, input int eb);
    check({tag, ".q"}, int'(q), eq);
    check({tag, ".tc"}, int'(tc), etc);
    check({tag, ".busy"}, int'(busy), eb);
  endtask

  task automatic step(input logic l, input int v, input logic e, input logic m);
    @(negedge clk);
    load = l; load_val = WIDTH'(v); en = e; mode = m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; mode = 1'b0;

    // one-shot, load 3
    vecs.push_back(mk(1, 3, 1, 0, 3, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    // auto-reload, load 2
    vecs.push_back(mk(1, 2, 1, 1, 2, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 2, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 2, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1));
    // one-shot, load 4, en toggling
    vecs.push_back(mk(1, 4, 0, 0, 4, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 3, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 3, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    // load from DONE, then load wins over expiry at q==0
    vecs.push_back(mk(1, 1, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 7, 1, 0, 7, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 7, 0, 1));
    // load 0 auto-reload: tc on every enabled cycle
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1));
    // mode switched to one-shot mid-run takes effect at expiry
    vecs.push_back(mk(1, 1, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0));
    // max load value
    vecs.push_back(mk(1, 15, 1, 0, 15, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 14, 0, 1));

    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // IDLE ignores en
    for (int i = 0; i < 3; i++) begin
      step(0, 9, 1, 1);
      check_out("idle_en", 0, 0, 0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].load, int'(vecs[i].val), vecs[i].en, vecs[i].mode);
      check_out($sformatf("vec%0d", i), int'(vecs[i].q), int'(vecs[i].tc), int'(vecs[i].busy));
    end

    // DONE holds q=0 for many cycles regardless of en
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    check_out("done_entry", 0, 1, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, (i % 2) == 0, 0);
      check_out("done_hold", 0, 0, 0);
    end

    // async reset mid-run at q=5
    step(1, 5, 0, 0);
    check_out("pre_rst", 5, 0, 1);
    #2;
    rst = 1'b0;
    #1;
    check_out("async_rst", 0, 0, 0);

    // async reset clears a high tc
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 1, 1);
    step(0, 0, 1, 1);
    check_out("tc_before_rst", 0, 1, 1);
    #1;
    rst = 1'b0;
    #1;
    check_out("rst_clears_tc", 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0);
      check_out("post_rst_idle", 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/down_counter_ctrl.md
Name: down_counter_ctrl

Overview:
- Synchronous, loadable down counter with terminal-count signalling. It is the count-down counterpart of the up counters in the counter library.
- Loaded with a start value, it decrements on enabled cycles and raises a one-cycle terminal-count pulse on expiry.
- It then stops (one-shot) or reloads (auto-reload).
- Used as a programmable timer/divider by neighbouring sequential blocks.

Parameters:
- WIDTH, 4, counter and load-value width in bits (>=2)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset; asserting (0) clears all state immediately, release is synchronous to clk
- load  input  1  load request; captures load_val into counter and reload register
- load_val  input  WIDTH  start/reload value
- en  input  1  count enable; one decrement per enabled cycle in RUN
- mode  input  1  0 = one-shot, 1 = auto-reload; sampled every cycle
- q  output  WIDTH  current count (registered)
- tc  output  1  terminal-count pulse, registered, high exactly one cycle per expiry
- busy  output  1  high while state is RUN

Behaviour:
- Reset (rst=0, async):
  - q=0, reload register=0, tc=0, busy=0, state=IDLE.
  - Holds while rst=0.
  - Reset mid-count aborts immediately; no tc is generated.
- States: IDLE, RUN, DONE. busy=1 only in RUN.
- load=1, any state:
  - next edge: q<=load_val, reload<=load_val, state<=RUN, tc<=0.
  - load has priority over en and over expiry in the same cycle.
- RUN, en=0: q, state hold; tc<=0.
- RUN, en=1, q!=0: q<=q-1 (no wrap past 0); tc<=0.
- RUN, en=1, q==0 (expiry):
  - tc<=1 for the next cycle only.
  - mode=0: state<=DONE, q stays 0.
  - mode=1: q<=reload, state stays RUN.
- Period arithmetic:
  - Expiry occurs on the (N+1)th enabled cycle after load of N.
  - Auto-reload period = reload+1 enabled cycles.
  - load_val=0 with mode=1 gives tc on every enabled cycle (tc held high while en=1).
- DONE: q=0 held, en ignored, tc=0; leaves only via load or reset.
- IDLE: q holds, en ignored, tc=0; leaves only via load.
- mode change while RUN takes effect at the next expiry; no other side effect.
- tc is never high in the cycle immediately after a load.
- All arithmetic modulo 2^WIDTH, but decrement is never applied at q==0.

Test Plan:
- rst=0 mid-RUN with q=5 (WIDTH=4) -> q=0, busy=0, tc=0 within same cycle (before next edge); after release, en pulses leave q=0 and state IDLE.
- load_val=3, mode=0, en=1 continuous -> q sequence 3,2,1,0; tc high one cycle on 5th edge after load; then busy=0, q=0 held for 10+ further cycles.
- load_val=2, mode=1, en=1 continuous for 12 cycles -> q 2,1,0,2,1,0,...; tc pulses every 3 cycles, each one cycle wide; busy stays 1.
- load_val=4, mode=0, en toggling 1,0,1,0... -> q decrements only on en=1 cycles; tc after the 5th enabled cycle; q holds across en=0 cycles.
- In RUN at q==0 with en=1, assert load=1 with load_val=7 same cycle -> q=7, tc stays 0, state RUN (load wins over expiry).
- load_val=0, mode=1, en=1 for 4 cycles -> q stays 0, tc high on each of the 4 following edges; drop en -> tc=0 next cycle.
